// File: rtl/tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tx_scheduler_pkg
//  Purpose  : Shared types and constants for the tx_scheduler block: FSM state
//             encodings, default timeout/gap values and a counter-width helper.
//  Options  : TX_SCHED_GAP_EN (consumed by tx_scheduler) enables the GAP state.
//  Revision : 1.0 - initial release
// ============================================================================
package tx_scheduler_pkg;

    // Scheduler FSM states; TXS_GAP is only reachable with TX_SCHED_GAP_EN
    typedef enum logic [2:0] {
        TXS_IDLE      = 3'd0,
        TXS_LOAD      = 3'd1,
        TXS_START     = 3'd2,
        TXS_WAIT_BUSY = 3'd3,
        TXS_SEND      = 3'd4,
        TXS_GAP       = 3'd5
    } txs_state_e;

    // Default cycle limits
    localparam int TXS_DEF_START_TIMEOUT = 255;
    localparam int TXS_DEF_GAP_CYCLES    = 1000;

    // Width of the shared cycle counter: must hold max(timeout, gap)
    function automatic int txs_cnt_width(input int timeout, input int gap);
        int m;
        m = (timeout > gap) ? timeout : gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tx_scheduler_rr_arbiter
//  Purpose  : Purely combinational round-robin arbiter. Returns the first set
//             request bit found scanning upward from ptr, wrapping at NUM_REQ.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_scheduler_rr_arbiter
    import tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       valid
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int idx;

    // Scan NUM_REQ positions starting at ptr; the first hit wins
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!valid && req[idx[IDX_W-1:0]]) begin
                valid  = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tx_scheduler
//  Purpose  : Round-robin scheduler sharing one serial transmitter among
//             NUM_REQ frame sources. Latches the winning frame, pulses
//             tx_start, follows tx_busy to completion and flags a transmitter
//             that never goes busy with a sticky err.
//  Options  : TX_SCHED_GAP_EN - insert GAP_CYCLES idle cycles after each
//             frame (SEND -> GAP -> IDLE). Undefined: SEND -> IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module tx_scheduler
    import tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 64,
    parameter int START_TIMEOUT = TXS_DEF_START_TIMEOUT,
    parameter int GAP_CYCLES    = TXS_DEF_GAP_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        tx_start,
    input  logic                        tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        active,
    output logic                        err
);

    localparam int                IDX_W     = $clog2(NUM_REQ);
    localparam int                CNT_W     = txs_cnt_width(START_TIMEOUT, GAP_CYCLES);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(START_TIMEOUT);
`ifdef TX_SCHED_GAP_EN
    localparam logic [CNT_W-1:0]  GAP_C     = CNT_W'(GAP_CYCLES);
`endif

    txs_state_e         state_q,    state_d;
    logic [IDX_W-1:0]   ptr_q,      ptr_d;
    logic [IDX_W-1:0]   winner_q,   winner_d;
    logic [IDX_W-1:0]   grant_q,    grant_d;
    logic [DATA_W-1:0]  tx_data_q,  tx_data_d;
    logic [NUM_REQ-1:0] ack_q,      ack_d;
    logic               tx_start_q, tx_start_d;
    logic               active_q,   active_d;
    logic               err_q,      err_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;

    logic [IDX_W-1:0]   arb_winner;
    logic               arb_valid;
    logic [DATA_W-1:0]  sel_data;
    logic [CNT_W-1:0]   cnt_inc;
    logic [IDX_W-1:0]   ptr_next;

    tx_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Select the frame of the source chosen in IDLE
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner_q == IDX_W'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Saturating counter increment and wrapping round-robin pointer advance
    always_comb begin
        cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        ptr_next = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
    end

    // FSM next-state and next-output logic; every output is registered
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        winner_d   = winner_q;
        grant_d    = grant_q;
        tx_data_d  = tx_data_q;
        ack_d      = '0;
        tx_start_d = 1'b0;
        err_d      = err_q;
        cnt_d      = cnt_q;

        case (state_q)
            TXS_IDLE: begin
                // Winner is decided here, so a req dropped during LOAD is still served
                if (arb_valid) begin
                    winner_d = arb_winner;
                    ack_d    = NUM_REQ'(1) << arb_winner;
                    state_d  = TXS_LOAD;
                end
            end
            TXS_LOAD: begin
                tx_data_d  = sel_data;
                grant_d    = winner_q;
                ptr_d      = ptr_next;
                tx_start_d = 1'b1;
                state_d    = TXS_START;
            end
            TXS_START: begin
                cnt_d   = '0;
                state_d = TXS_WAIT_BUSY;
            end
            TXS_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = TXS_SEND;
                end else begin
                    cnt_d = cnt_inc;
                    // Give up after START_TIMEOUT low samples; scheduling resumes
                    if (cnt_inc >= TIMEOUT_C) begin
                        err_d   = 1'b1;
                        state_d = TXS_IDLE;
                    end
                end
            end
            TXS_SEND: begin
                if (!tx_busy) begin
`ifdef TX_SCHED_GAP_EN
                    cnt_d   = '0;
                    state_d = TXS_GAP;
`else
                    state_d = TXS_IDLE;
`endif
                end
            end
`ifdef TX_SCHED_GAP_EN
            TXS_GAP: begin
                // Hold off the next frame so the receiver can resynchronise
                if (cnt_inc >= GAP_C) begin
                    state_d = TXS_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif
            default: begin
                state_d = TXS_IDLE;
            end
        endcase

        active_d = (state_d != TXS_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TXS_IDLE;
            ptr_q      <= '0;
            winner_q   <= '0;
            grant_q    <= '0;
            tx_data_q  <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            grant_q    <= grant_d;
            tx_data_q  <= tx_data_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            active_q   <= active_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ack      = ack_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign grant_id = grant_q;
    assign active   = active_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tx_scheduler
//  Purpose  : Directed self-checking bench for tx_scheduler (NUM_REQ=4,
//             START_TIMEOUT=8, GAP_CYCLES=10). Honours TX_SCHED_GAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tx_scheduler;

    localparam int NUM_REQ       = 4;
    localparam int DATA_W        = 64;
    localparam int START_TIMEOUT = 8;
    localparam int GAP_CYCLES    = 10;
`ifdef TX_SCHED_GAP_EN
    localparam int SETTLE        = GAP_CYCLES + 1;
`else
    localparam int SETTLE        = 1;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic [1:0]                grant_id;
    logic                      active;
    logic                      err;

    logic [DATA_W-1:0] frames [NUM_REQ];

    int checks   = 0;
    int failures = 0;

    tx_scheduler #(
        .NUM_REQ       (NUM_REQ),
        .DATA_W        (DATA_W),
        .START_TIMEOUT (START_TIMEOUT),
        .GAP_CYCLES    (GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .grant_id (grant_id),
        .active   (active),
        .err      (err)
    );

    always #5 clk = ~clk;

    assign req_data = {frames[3], frames[2], frames[1], frames[0]};

    // Advance one cycle; drive and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for an ack pulse and compare it to the expected one-hot
    task automatic wait_ack(input string tag, input logic [3:0] exp);
        int n = 0;
        while (ack == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 64'(ack), 64'(exp));
    endtask

    // Called in the ack cycle: drop req, check start/data/grant, run a short busy pulse
    task automatic finish_frame(input string tag, input int idx);
        int n = 0;
        req[idx] = 1'b0;
        tick();
        check({tag, "_start"}, 64'(tx_start), 64'd1);
        check({tag, "_data"},  tx_data, frames[idx]);
        check({tag, "_grant"}, 64'(grant_id), 64'(idx));
        tick();
        tx_busy = 1'b1;
        tick();
        tx_busy = 1'b0;
        while (active == 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_settle"}, 64'(n), 64'(SETTLE));
    endtask

    initial begin
        int n;
        int starts;
        int acks;
        int lows;

        frames[0] = 64'h0123_4567_89AB_CDEF;
        frames[1] = 64'hDEAD_BEEF_0000_0001;
        frames[2] = 64'hA5A5_5A5A_C3C3_3C3C;
        frames[3] = 64'hFFFF_0000_FFFF_0002;
        rst     = 1'b1;
        req     = '0;
        tx_busy = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_ack",    64'(ack), 64'd0);
        check("rst_start",  64'(tx_start), 64'd0);
        check("rst_data",   tx_data, 64'd0);
        check("rst_grant",  64'(grant_id), 64'd0);
        check("rst_active", 64'(active), 64'd0);
        check("rst_err",    64'(err), 64'd0);
        rst = 1'b0;
        tick();

        // Test 1: single source, busy rises 3 cycles after start and holds 200 cycles
        req = 4'b0001;
        tick();
        check("t1_ack", 64'(ack), 64'b0001);
        check("t1_active", 64'(active), 64'd1);
        req = 4'b0000;
        tick();
        check("t1_start", 64'(tx_start), 64'd1);
        check("t1_data", tx_data, frames[0]);
        tick();
        check("t1_start_pulse", 64'(tx_start), 64'd0);
        tick();
        tick();
        tx_busy = 1'b1;
        starts = 0;
        acks   = 0;
        lows   = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx_start) starts++;
            if (ack != 4'b0) acks++;
            if (!active) lows++;
        end
        check("t1_extra_starts", 64'(starts), 64'd0);
        check("t1_extra_acks", 64'(acks), 64'd0);
        check("t1_active_low", 64'(lows), 64'd0);
        check("t1_data_hold", tx_data, frames[0]);
        tx_busy = 1'b0;
        n = 0;
        while (active == 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("t1_active_fall", 64'(n), 64'(SETTLE));
        check("t1_err", 64'(err), 64'd0);

        // Test 2: all four request together, served strictly in order 0..3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        wait_ack("t2_ack0", 4'b0001);
        finish_frame("t2_f0", 0);
        wait_ack("t2_ack1", 4'b0010);
        finish_frame("t2_f1", 1);
        wait_ack("t2_ack2", 4'b0100);
        finish_frame("t2_f2", 2);
        wait_ack("t2_ack3", 4'b1000);
        finish_frame("t2_f3", 3);

        // Test 3: pointer moved to 3, then 1001 -> source 3 before source 0
        req = 4'b0100;
        wait_ack("t3_ack2", 4'b0100);
        finish_frame("t3_f2", 2);
        req = 4'b1001;
        wait_ack("t3_ack3", 4'b1000);
        finish_frame("t3_f3", 3);
        wait_ack("t3_ack0", 4'b0001);
        finish_frame("t3_f0", 0);

        // Test 4: busy never rises -> err START_TIMEOUT+1 cycles after tx_start
        req = 4'b0010;
        wait_ack("t4_ack1", 4'b0010);
        req = 4'b0000;
        tick();
        check("t4_start", 64'(tx_start), 64'd1);
        n = 0;
        while (err == 1'b0 && n < 50) begin
            tick();
            n++;
        end
        check("t4_err_delay", 64'(n), 64'(START_TIMEOUT + 1));
        check("t4_idle_after_err", 64'(active), 64'd0);
        req = 4'b0100;
        wait_ack("t4_ack_after_err", 4'b0100);
        finish_frame("t4_f2", 2);
        check("t4_err_sticky", 64'(err), 64'd1);

        // Test 5: reset during SEND aborts and clears the pointer
        req = 4'b0100;
        wait_ack("t5_ack2", 4'b0100);
        req = 4'b0000;
        tick();
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        check("t5_in_send", 64'(active), 64'd1);
        rst = 1'b1;
        tx_busy = 1'b0;
        tick();
        check("t5_ack",    64'(ack), 64'd0);
        check("t5_start",  64'(tx_start), 64'd0);
        check("t5_data",   tx_data, 64'd0);
        check("t5_grant",  64'(grant_id), 64'd0);
        check("t5_active", 64'(active), 64'd0);
        check("t5_err",    64'(err), 64'd0);
        rst = 1'b0;
        req = 4'b1001;
        wait_ack("t5_ptr_zero", 4'b0001);
        finish_frame("t5_f0", 0);
        req = 4'b0000;
        tick();

`ifdef TX_SCHED_GAP_EN
        // Test 6: back-to-back frames separated by the gap
        req = 4'b1001;
        wait_ack("t6_ack3", 4'b1000);
        req = 4'b0001;
        tick();
        check("t6_start0", 64'(tx_start), 64'd1);
        tick();
        tx_busy = 1'b1;
        tick();
        tx_busy = 1'b0;
        n = 0;
        lows = 0;
        while (tx_start == 1'b0 && n < 60) begin
            tick();
            n++;
            if (!active) lows++;
        end
        check("t6_gap_ge12", 64'(n >= 12), 64'd1);
        check("t6_second_data", tx_data, frames[0]);
        req = 4'b0000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
